// File: rtl/hls_prims_pkg.sv
// Constants shared by the HLS leaf primitives and the blocks that combine them.
package hls_prims_pkg;

  localparam int BB_ID_WIDTH_DEF = 32;
  // Block ID the control FSM reports as the function entry; last_block resets to it.
  localparam int ENTRY_BB        = 0;

endpackage

// File: rtl/hls_phi_add_if.sv
// Bundle of the basic-block report, phi operands and adder results around hls_phi_add.
interface hls_phi_add_if
  import hls_prims_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NB_PAIR     = 2,
  parameter int BB_ID_WIDTH = BB_ID_WIDTH_DEF
);

  logic                           bb_valid;
  logic [BB_ID_WIDTH-1:0]         bb_id;
  logic [NB_PAIR*WIDTH-1:0]       phi_in;
  logic [NB_PAIR*BB_ID_WIDTH-1:0] phi_s;
  logic [WIDTH-1:0]               add_in1;
  logic [BB_ID_WIDTH-1:0]         last_block;
  logic [WIDTH-1:0]               phi_out;
  logic                           phi_hit;
  logic [WIDTH-1:0]               sum_out;

  modport master (
    output bb_valid, bb_id, phi_in, phi_s, add_in1,
    input  last_block, phi_out, phi_hit, sum_out
  );

  modport slave (
    input  bb_valid, bb_id, phi_in, phi_s, add_in1,
    output last_block, phi_out, phi_hit, sum_out
  );

endinterface

// File: rtl/hls_phi_add_add.sv
// add primitive: WIDTH-bit wrap-around adder, carry discarded.
module add #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out
);

  assign out = in0 + in1;

endmodule

// File: rtl/hls_phi_add_br_dummy.sv
// Branch primitive: carries no logic, exists so each branch leaves one unit in the netlist.
module br_dummy;
endmodule

// File: rtl/hls_phi_add_phi.sv
// phi primitive: picks the value whose predecessor block ID matches the last completed block.
module phi
  import hls_prims_pkg::*;
#(
  parameter int NB_PAIR     = 2,
  parameter int WIDTH       = 8,
  parameter int BB_ID_WIDTH = BB_ID_WIDTH_DEF
) (
  input  logic [NB_PAIR*WIDTH-1:0]       in,
  input  logic [NB_PAIR*BB_ID_WIDTH-1:0] s,
  input  logic [BB_ID_WIDTH-1:0]         last_block,
  output logic [WIDTH-1:0]               out,
  output logic                           hit
);

  // Scan from the top down so the lowest matching index is the last writer.
  always_comb begin
    out = '0;
    hit = 1'b0;
    for (int i = NB_PAIR - 1; i >= 0; i--) begin
      if (s[i*BB_ID_WIDTH +: BB_ID_WIDTH] == last_block) begin
        out = in[i*WIDTH +: WIDTH];
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hls_phi_add.sv
// Phi select of the last completed block's value, followed by a wrap-around increment.
module hls_phi_add
  import hls_prims_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NB_PAIR     = 2,
  parameter int BB_ID_WIDTH = BB_ID_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  hls_phi_add_if.slave bus
);

  logic [BB_ID_WIDTH-1:0] r_last_block;
  logic [WIDTH-1:0]       w_phi_out;
  logic                   w_phi_hit;
  logic [WIDTH-1:0]       w_sum_out;

  always_ff @(posedge clk) begin
    if (rst)
      r_last_block <= BB_ID_WIDTH'(ENTRY_BB);
    else if (bus.bb_valid)
      r_last_block <= bus.bb_id;
  end

  // Selection and add are combinational from the register; no path loops back into it.
  phi #(
    .NB_PAIR     (NB_PAIR),
    .WIDTH       (WIDTH),
    .BB_ID_WIDTH (BB_ID_WIDTH)
  ) u_phi (
    .in         (bus.phi_in),
    .s          (bus.phi_s),
    .last_block (r_last_block),
    .out        (w_phi_out),
    .hit        (w_phi_hit)
  );

  add #(
    .WIDTH (WIDTH)
  ) u_add (
    .in0 (w_phi_out),
    .in1 (bus.add_in1),
    .out (w_sum_out)
  );

  br_dummy u_br ();

  assign bus.last_block = r_last_block;
  assign bus.phi_out    = w_phi_out;
  assign bus.phi_hit    = w_phi_hit;
  assign bus.sum_out    = w_sum_out;

endmodule

// File: tb/tb_hls_phi_add.sv
// Scoreboard bench for hls_phi_add at WIDTH=8, NB_PAIR=2, BB_ID_WIDTH=32.
module tb_hls_phi_add;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hls_phi_add_if #(.WIDTH(8), .NB_PAIR(2), .BB_ID_WIDTH(32)) bus ();

  hls_phi_add #(.WIDTH(8), .NB_PAIR(2), .BB_ID_WIDTH(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] last;
    logic [7:0]  phi;
    logic        hit;
    logic [7:0]  sum;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] m_last = 32'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] last, input logic [15:0] pin,
                                 input logic [63:0] ps, input logic [7:0] a1);
    exp_t e;
    e.last = last;
    e.phi  = 8'h00;
    e.hit  = 1'b0;
    if (ps[31:0] == last) begin
      e.phi = pin[7:0];
      e.hit = 1'b1;
    end else if (ps[63:32] == last) begin
      e.phi = pin[15:8];
      e.hit = 1'b1;
    end
    e.sum = 8'(e.phi + a1);
    return e;
  endfunction

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_last"}, 64'(bus.last_block), 64'(e.last));
    chk({tag, "_phi"},  64'(bus.phi_out),    64'(e.phi));
    chk({tag, "_hit"},  64'(bus.phi_hit),    64'(e.hit));
    chk({tag, "_sum"},  64'(bus.sum_out),    64'(e.sum));
  endtask

  // One clock edge with the given control and operands, outputs checked just after it.
  task automatic step(input string tag, input logic r, input logic v, input logic [31:0] id,
                      input logic [15:0] pin, input logic [63:0] ps, input logic [7:0] a1);
    logic [31:0] nl;
    rst          = r;
    bus.bb_valid = v;
    bus.bb_id    = id;
    bus.phi_in   = pin;
    bus.phi_s    = ps;
    bus.add_in1  = a1;
    nl = r ? 32'd0 : (v ? id : m_last);
    sb.push_back(model(nl, pin, ps, a1));
    @(posedge clk);
    #1;
    m_last = nl;
    compare(tag);
  endtask

  // Operand change without a clock edge: outputs must follow at once.
  task automatic comb(input string tag, input logic [15:0] pin, input logic [63:0] ps,
                      input logic [7:0] a1);
    bus.bb_valid = 1'b0;
    bus.phi_in   = pin;
    bus.phi_s    = ps;
    bus.add_in1  = a1;
    sb.push_back(model(m_last, pin, ps, a1));
    #1;
    compare(tag);
  endtask

  localparam logic [63:0] PS10 = {32'd1, 32'd0};

  initial begin
    logic [7:0] cnt;
    logic [7:0] m_cnt;
    rst          = 1'b1;
    bus.bb_valid = 1'b0;
    bus.bb_id    = '0;
    bus.phi_in   = '0;
    bus.phi_s    = '0;
    bus.add_in1  = '0;

    step("rst0", 1'b1, 1'b0, 32'd0, {8'h05, 8'h00}, PS10, 8'h01);
    step("rst1", 1'b1, 1'b0, 32'd0, {8'h05, 8'h00}, PS10, 8'h01);
    chk("rst_sum_const", 64'(bus.sum_out), 64'h01);

    step("load1", 1'b0, 1'b1, 32'd1, {8'h05, 8'h00}, PS10, 8'h01);
    chk("load1_sum_const", 64'(bus.sum_out), 64'h06);
    step("hold1", 1'b0, 1'b0, 32'd9, {8'h05, 8'h00}, PS10, 8'h01);

    comb("wrap", {8'hFF, 8'h00}, PS10, 8'h01);
    chk("wrap_sum_const", 64'(bus.sum_out), 64'h00);
    comb("comb_a1", {8'h80, 8'h11}, PS10, 8'h7F);

    step("nomatch", 1'b0, 1'b1, 32'd7, {8'h05, 8'h00}, PS10, 8'h2C);
    chk("nomatch_sum_const", 64'(bus.sum_out), 64'h2C);

    step("dup_load", 1'b0, 1'b1, 32'd3, {8'hAA, 8'h55}, {32'd3, 32'd3}, 8'h00);
    chk("dup_phi_const", 64'(bus.phi_out), 64'h55);
    step("hi_id", 1'b0, 1'b1, 32'hFFFF_FFFF, {8'h3C, 8'hC3}, {32'hFFFF_FFFF, 32'd5}, 8'h04);

    step("back2back0", 1'b0, 1'b1, 32'd0, {8'h12, 8'h34}, PS10, 8'h01);
    step("back2back1", 1'b0, 1'b1, 32'd1, {8'h12, 8'h34}, PS10, 8'h01);

    step("rst_vs_vld", 1'b1, 1'b1, 32'd1, {8'h05, 8'h09}, PS10, 8'h01);
    chk("rst_vs_vld_phi_const", 64'(bus.phi_out), 64'h09);

    // Counter built from the block: its sum fed back into both phi inputs.
    cnt   = 8'h00;
    m_cnt = 8'h00;
    for (int i = 0; i < 100; i++) begin
      step("cnt", 1'b0, 1'b1, 32'(i % 2), {cnt, cnt}, PS10, 8'h01);
      cnt   = bus.sum_out;
      m_cnt = m_cnt + 8'h01;
      chk("cnt_value", 64'(cnt), 64'(m_cnt));
    end

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
